// File: rtl/blink_pkg.sv
// blink_pkg: state encoding and default tick constants for the blink-code arbiter.
package blink_pkg;
  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;
  localparam int DEF_ON_TICKS = 1200000;
  localparam int DEF_OFF_TICKS = 2400000;
  localparam int DEF_GAP_TICKS = 12000000;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b ? a : b) > c ? (a > b ? a : b) : c;
  endfunction
endpackage

// File: rtl/tick_timer.sv
// tick_timer: loadable down-counter that parks at zero and flags done there.
module tick_timer #(
  parameter int W = 24
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign done = cnt == '0;
endmodule

// File: rtl/blink_code_arbiter.sv
// blink_code_arbiter: round-robin shares one green LED, blinking each winner's pulse-count code.
module blink_code_arbiter
  import blink_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int CNT_W = 4,
  parameter int PULSE_ON_TICKS = DEF_ON_TICKS,
  parameter int PULSE_OFF_TICKS = DEF_OFF_TICKS,
  parameter int GAP_TICKS = DEF_GAP_TICKS
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*CNT_W-1:0] CODE,
  output logic [NREQ-1:0]       ACK,
  output logic [NREQ-1:0]       GNT,
  output logic                  BUSY,
  output logic                  LEDG_N
);
  localparam int TMAX = max3(PULSE_ON_TICKS, PULSE_OFF_TICKS, GAP_TICKS);
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam logic [TW-1:0] ON_LD = TW'(PULSE_ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LD = TW'(PULSE_OFF_TICKS - 1);
  localparam logic [TW-1:0] GAP_LD = TW'(GAP_TICKS - 1);
  if (PULSE_ON_TICKS < 1 || PULSE_OFF_TICKS < 1 || GAP_TICKS < 1) begin : g_bad_ticks
    $error("blink_code_arbiter: tick parameters must be at least 1");
  end
  state_t state;
  logic [CNT_W-1:0] rem, win_code;
  logic [PW-1:0] ptr, win, next_ptr;
  logic [NREQ-1:0] win_oh;
  logic found, load, done;
  logic [TW-1:0] ld_val;
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++)
      if (!found && REQ[(int'(ptr) + k) % NREQ]) begin
        win = PW'((int'(ptr) + k) % NREQ);
        found = 1'b1;
      end
  end
  assign win_code = CODE[win*CNT_W +: CNT_W];
  assign win_oh = NREQ'(1) << win;
  assign next_ptr = win == PW'(NREQ - 1) ? '0 : win + PW'(1);
  // Timer is reloaded on the same edge that moves the state register.
  assign load = (state == IDLE && |REQ) || ((state == ON || state == OFF) && done);
  assign ld_val = state == IDLE ? (win_code != '0 ? ON_LD : GAP_LD) :
                  state == ON   ? (rem == CNT_W'(1) ? GAP_LD : OFF_LD) : ON_LD;
  tick_timer #(.W(TW)) u_timer (
    .CLK(CLK), .RST(RST), .load(load), .load_val(ld_val), .done(done)
  );
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      rem <= '0;
      ptr <= '0;
      ACK <= '0;
      GNT <= '0;
      BUSY <= 1'b0;
      LEDG_N <= 1'b1;
    end else begin
      ACK <= '0;
      case (state)
        IDLE: if (|REQ) begin
          state <= win_code != '0 ? ON : GAP;
          rem <= win_code;
          ptr <= next_ptr;
          ACK <= win_oh;
          GNT <= win_oh;
          BUSY <= 1'b1;
          LEDG_N <= win_code == '0;
        end
        ON: if (done) begin
          rem <= rem - CNT_W'(1);
          state <= rem == CNT_W'(1) ? GAP : OFF;
          LEDG_N <= 1'b1;
        end
        OFF: if (done) begin
          state <= ON;
          LEDG_N <= 1'b0;
        end
        GAP: if (done) begin
          state <= IDLE;
          GNT <= '0;
          BUSY <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blink_code_arbiter.sv
// tb_blink_code_arbiter: directed grants with a scoreboard monitor that measures each blinked code.
module tb_blink_code_arbiter;
  logic CLK = 1'b0, RST = 1'b1;
  logic [2:0] REQ = '0;
  logic [11:0] CODE = '0;
  logic [2:0] ACK, GNT;
  logic BUSY, LEDG_N;
  typedef struct {int idx; int pulses; int gap;} txn_t;
  txn_t exp_q[$];
  int checks = 0, errors = 0;
  bit active = 1'b0;

  blink_code_arbiter #(
    .NREQ(3), .CNT_W(4), .PULSE_ON_TICKS(2), .PULSE_OFF_TICKS(3), .GAP_TICKS(5)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .CODE(CODE),
    .ACK(ACK), .GNT(GNT), .BUSY(BUSY), .LEDG_N(LEDG_N)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic void push(input int i, input int p);
    exp_q.push_back('{idx: i, pulses: p, gap: 5});
  endfunction

  // Monitor: pops the expected grant on each ACK and measures the blink train until BUSY drops.
  initial begin
    txn_t cur;
    int npulse, low_run, high_run;
    bit prev_led, ok;
    forever begin
      @(negedge CLK);
      if (RST) begin
        active = 1'b0;
        continue;
      end
      if (active && !BUSY) begin
        check("pulses", npulse, cur.pulses);
        check("gap_len", high_run, cur.gap);
        check("timing", int'(ok && prev_led), 1);
        active = 1'b0;
      end
      if (ACK != '0) begin
        if (active) check("extra_ack", int'(ACK), 0);
        else if (exp_q.size() == 0) check("unexpected_ack", int'(ACK), 0);
        else begin
          cur = exp_q.pop_front();
          check("ack_idx", int'(ACK), 1 << cur.idx);
          check("gnt_at_ack", int'(GNT), 1 << cur.idx);
          active = 1'b1;
          npulse = 0;
          low_run = 0;
          high_run = 0;
          prev_led = 1'b1;
          ok = 1'b1;
        end
      end
      if (active) begin
        if (int'(GNT) != (1 << cur.idx)) ok = 1'b0;
        if (!LEDG_N) begin
          if (prev_led) begin
            if (npulse > 0 && high_run != 3) ok = 1'b0;
            low_run = 0;
          end
          low_run++;
        end else begin
          if (!prev_led) begin
            if (low_run != 2) ok = 1'b0;
            npulse++;
            high_run = 0;
          end
          high_run++;
        end
        prev_led = LEDG_N;
      end
    end
  end

  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK);
      got = ACK != '0;
    end
    if (!got) check("ack_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge CLK);
      idle = !BUSY;
    end
    if (!idle) check("idle_timeout", 0, 1);
  endtask

  // Drops REQ and scrambles CODE right after the last ACK, so the latched count must still play.
  task automatic run(input logic [2:0] r, input logic [11:0] c, input int nack);
    bit got = 1'b1;
    REQ = r;
    CODE = c;
    for (int n = 0; n < nack && got; n++) wait_ack(got);
    REQ = '0;
    CODE = '1;
    wait_idle();
    repeat (2) @(negedge CLK);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_led"}, int'(LEDG_N), 1);
    check({tag, "_gnt"}, int'(GNT), 0);
    check({tag, "_busy"}, int'(BUSY), 0);
    check({tag, "_ack"}, int'(ACK), 0);
  endtask

  initial begin
    bit got;
    repeat (2) @(negedge CLK);
    check_reset("reset");
    RST = 1'b0;
    @(negedge CLK);
    push(0, 1); push(1, 1); push(2, 1); push(0, 1);
    run(3'b111, {4'd1, 4'd1, 4'd1}, 4);
    push(1, 0);
    run(3'b010, {4'd7, 4'd0, 4'd9}, 1);
    push(0, 3);
    run(3'b001, {4'd7, 4'd7, 4'd3}, 1);
    push(0, 5);
    run(3'b001, {4'd2, 4'd2, 4'd5}, 1);
    push(0, 15);
    run(3'b001, {4'd0, 4'd0, 4'd15}, 1);
    push(0, 3);
    REQ = 3'b001;
    CODE = {4'd1, 4'd1, 4'd3};
    wait_ack(got);
    REQ = '0;
    repeat (5) @(negedge CLK);
    check("second_on_led", int'(LEDG_N), 0);
    #2 RST = 1'b1;
    #1 check_reset("async_rst");
    @(negedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    push(2, 2);
    run(3'b100, {4'd2, 4'd4, 4'd4}, 1);
    for (int i = 0; i < 50 && (exp_q.size() != 0 || active); i++) @(negedge CLK);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/blink_code_arbiter.md
BLINK_CODE_ARBITER -- requirements
Module: blink_code_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of requesters sharing the green LED.
REQ-002 Parameter CNT_W, default 4: width of each requester's pulse-count code.
REQ-003 Parameter PULSE_ON_TICKS, default 1200000: LED-lit cycles per pulse (100 ms at 12 MHz).
REQ-004 Parameter PULSE_OFF_TICKS, default 2400000: LED-dark cycles between pulses of one code.
REQ-005 Parameter GAP_TICKS, default 12000000: LED-dark cycles after the last pulse of a code.
REQ-006 CLK  input  1  12 MHz clock, single clock domain.
REQ-007 RST  input  1  reset, asynchronous, active-high.
REQ-008 REQ  input  NREQ  per-requester request level, held until ACK.
REQ-009 CODE  input  NREQ*CNT_W  flat pulse counts; requester i occupies bits [i*CNT_W +: CNT_W]; stable while REQ[i] is high.
REQ-010 ACK  output  NREQ  one-cycle pulse to the accepted requester.
REQ-011 GNT  output  NREQ  one-hot owner of the LED; held from acceptance until the gap ends.
REQ-012 BUSY  output  1  high in any state other than IDLE.
REQ-013 LEDG_N  output  1  green LED, active-low, registered.

Function
REQ-014 FSM states: IDLE, ON, OFF, GAP.
REQ-015 IDLE with any REQ bit high: next edge selects a winner round-robin, starting at the index after the last granted index (index 0 first after reset), latches its CODE into remaining, pulses ACK[winner], sets GNT[winner].
REQ-016 From IDLE, latched code nonzero -> ON; latched code zero -> GAP (no pulses).
REQ-017 ON lasts exactly PULSE_ON_TICKS cycles with LEDG_N=0; at exit remaining decrements; remaining then 0 -> GAP, else -> OFF.
REQ-018 OFF lasts exactly PULSE_OFF_TICKS cycles with LEDG_N=1, then -> ON.
REQ-019 GAP lasts exactly GAP_TICKS cycles with LEDG_N=1, then -> IDLE; GNT clears on entering IDLE.
REQ-020 IDLE lasts at least one cycle; arbitration is never performed in the cycle GAP exits.
REQ-021 LEDG_N=0 only in ON; LEDG_N changes in the same cycle as the state register.
REQ-022 REQ changes while BUSY are ignored; a requester that keeps REQ high after ACK is replayed when next granted.
REQ-023 Timer width = clog2 of the largest of the three tick parameters; the timer never wraps.
REQ-024 Any tick parameter below 1 is illegal.

Reset
REQ-025 RST asserted: state=IDLE, timer=0, remaining=0, RR pointer=0, ACK=0, GNT=0, BUSY=0, LEDG_N=1, all immediately and independent of CLK.
REQ-026 RST mid-code aborts the code with no ACK or replay; the first grant after release follows REQ-015 with pointer 0.

Structure
REQ-027 Package blink_pkg holds the state encoding and the default tick constants.
REQ-028 Sub-module tick_timer: loadable down-counter with a done flag, instantiated once and reloaded at every state entry.
REQ-029 The round-robin select and the FSM reside in blink_code_arbiter.

Verification (bench params: ON=2, OFF=3, GAP=5, NREQ=3, CNT_W=4)
REQ-030 REQ=001, CODE0=3 -> ACK0 for 1 cycle; LEDG_N low 2 / high 3 / low 2 / high 3 / low 2, then high 5; BUSY falls; GNT=001 throughout.
REQ-031 REQ=111 held, all codes=1 -> grant order 0,1,2,0; each grant yields one 2-cycle low pulse plus a 5-cycle gap.
REQ-032 REQ=010, CODE1=0 -> ACK1; LEDG_N stays high; GAP lasts 5 cycles; back to IDLE.
REQ-033 RST asserted during the 2nd ON of code 3 -> LEDG_N=1, GNT=0, BUSY=0 with no clock edge; after release REQ=100 is granted to requester 2.
REQ-034 REQ=001 dropped the cycle after ACK with CODE0 changed -> the full latched count still plays; no second ACK.
REQ-035 CODE0=15 -> exactly 15 low pulses; timer and remaining show no overflow.
